anode_scanner: RTL and testbench
================================

# anode_scanner

Parametrised multiplexed seven-segment display driver. It time-slices NUM_DIGITS digits over shared segment lines and drives one active-low anode per digit. Each digit slot has a programmable lit window with blanking guard ticks at either edge to suppress ghosting. Digit data is snapshotted once per frame, and segments are decoded from hex internally. It sits between the board-level digit value registers and the display pins, and replaces the fixed 4-digit, counter-driven anode decoding.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits/anodes; valid range 2..8.
- TICK_DIV, 50000: clk cycles per scan tick; must be ≥ 1.
- SLOT_TICKS, 4: ticks per digit slot; must be ≥ 1.
- ON_FIRST, 2: first tick index (0-based) in a slot where the anode is lit.
- ON_LAST, 2: last lit tick index; ON_FIRST ≤ ON_LAST < SLOT_TICKS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  hex value per digit; digit i occupies [4i+3:4i].
- dp  in  NUM_DIGITS  decimal point request per digit, active high.
- digit_en  in  NUM_DIGITS  per-digit enable; a disabled digit stays dark for its whole slot.
- an  out  NUM_DIGITS  anodes, active low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- digit_idx  out  clog2(NUM_DIGITS)  index of the slot currently being scanned.
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps. tick is asserted when div_cnt == TICK_DIV-1.
- Slot counter: on each tick, tick_cnt advances through 0..SLOT_TICKS-1. On wrap, digit_idx advances through 0..NUM_DIGITS-1 and wraps to 0.
- Frame snapshot: when digit_idx wraps to 0 (tick with tick_cnt == SLOT_TICKS-1 and digit_idx == NUM_DIGITS-1):
  - digits, dp and digit_en are latched into shadow registers;
  - frame_start pulses for one cycle.
  - Input changes made mid-frame never appear until the next frame.
- Lit condition: lit = (ON_FIRST ≤ tick_cnt ≤ ON_LAST) && en_sh[digit_idx].
- Output when lit:
  - an has only bit digit_idx low;
  - seg = hex decode of digits_sh[digit_idx];
  - dp_n = ~dp_sh[digit_idx].
- Output when not lit: an all ones, seg = 7'h7F, dp_n = 1. Segments are never driven while all anodes are off.
- Hex decode (active low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78;
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- At most one anode bit is low in any cycle. This holds through all wraps and parameter corners.

## Timing
- Reset values: an all ones, seg 7'h7F, dp_n 1, digit_idx 0, frame_start 0. div_cnt, tick_cnt and all shadow registers reset to 0.
- Reset mid-frame takes effect on the next clk edge. Outputs blank that cycle.
- After reset release:
  - the first tick occurs TICK_DIV cycles later;
  - the first frame snapshot occurs after NUM_DIGITS*SLOT_TICKS ticks;
  - until that snapshot, en_sh = 0, so the display stays dark.
- an, seg, dp_n, digit_idx and frame_start are registered. They reflect counter state with exactly one clk of latency, and all change on the same edge.
- Period per digit slot: TICK_DIV*SLOT_TICKS cycles. Frame period: NUM_DIGITS times that.
- Lit window per slot: (ON_LAST-ON_FIRST+1)*TICK_DIV cycles.
- TICK_DIV == 1 is legal: tick is then asserted every cycle.
- SLOT_TICKS == 1 with ON_FIRST == ON_LAST == 0 is legal and gives a 100% duty, no-guard scan.

## Test plan
- Reset and legacy equivalence:
  - setup: TICK_DIV=1, SLOT_TICKS=4, ON_FIRST=ON_LAST=2, digit_en=4'hF, digits=16'h3210;
  - hold reset 3 cycles, then run 2 frames;
  - during reset: an=4'hF, seg=7'h7F;
  - in the second frame, an goes low only at tick_cnt 2 of each slot, in order 1110, 1101, 1011, 0111;
  - seg is 7'h40, 7'h79, 7'h24, 7'h30 respectively.
- Frame snapshot:
  - change digits from 16'h3210 to 16'hFFFF while digit_idx == 1;
  - digits 1..3 still show 1, 2, 3 for that frame;
  - the next frame shows 7'h0E on all digits;
  - frame_start pulses exactly once per 16 cycles.
- Enable mask and dp:
  - set digit_en=4'b0101, dp=4'b0100;
  - slots 1 and 3 keep an=4'hF and seg=7'h7F for the full slot;
  - slot 2 is lit with dp_n=0;
  - slot 0 is lit with dp_n=1.
- Wide window, 8 digits:
  - setup: NUM_DIGITS=8, TICK_DIV=3, SLOT_TICKS=5, ON_FIRST=1, ON_LAST=3;
  - each anode is low for 9 consecutive cycles per 15-cycle slot;
  - digit_idx wraps 7→0 and frame_start coincides with the wrap;
  - the one-hot-low invariant is checked every cycle.
- Reset mid-lit:
  - assert reset while an=4'b1011;
  - on the next edge, an=4'hF and digit_idx=0;
  - after release, the display stays dark until the first post-reset snapshot.

Source files
------------

// File: rtl/anode_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : anode_scanner
//  Purpose  : Multiplexed seven-segment driver with per-slot guard blanking,
//             per-frame input snapshot and internal hex decode.
//  Revision : 1.0  initial release
// ============================================================================
module anode_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50000,
   parameter int SLOT_TICKS = 4,
   parameter int ON_FIRST   = 2,
   parameter int ON_LAST    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       digits,
   input  logic [NUM_DIGITS-1:0]         dp,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seg,
   output logic                          dp_n,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_start
);

   // Degenerate divisors still need a one-bit counter to keep widths legal.
   localparam int c_dw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_tw = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
   localparam int c_iw = $clog2(NUM_DIGITS);

   localparam logic [c_dw-1:0] c_div_last  = c_dw'(TICK_DIV - 1);
   localparam logic [c_tw-1:0] c_tick_last = c_tw'(SLOT_TICKS - 1);
   localparam logic [c_iw-1:0] c_idx_last  = c_iw'(NUM_DIGITS - 1);
   localparam logic [6:0]      c_seg_off   = 7'h7F;

   logic [c_dw-1:0]         r_div;
   logic [c_tw-1:0]         r_tick;
   logic [c_iw-1:0]         r_idx;
   logic                    r_frame_pend;
   logic [4*NUM_DIGITS-1:0] r_dig_sh;
   logic [NUM_DIGITS-1:0]   r_dp_sh;
   logic [NUM_DIGITS-1:0]   r_en_sh;

   logic                    w_tick;
   logic                    w_slot_wrap;
   logic                    w_frame_wrap;
   logic [(2**c_tw)-1:0]    w_win;
   logic [3:0]              w_dig_arr [NUM_DIGITS];
   logic [3:0]              w_cur_dig;
   logic                    w_cur_dp;
   logic                    w_lit;
   logic [6:0]              w_seg_dec;
   logic [NUM_DIGITS-1:0]   w_an_sel;

   assign w_tick       = (r_div == c_div_last);
   assign w_slot_wrap  = w_tick && (r_tick == c_tick_last);
   assign w_frame_wrap = w_slot_wrap && (r_idx == c_idx_last);

   // Prescaler, tick-in-slot and slot index counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= '0;
         r_idx  <= '0;
      end else begin
         if (w_tick) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + c_dw'(1);
         end
         if (w_slot_wrap) begin
            r_tick <= '0;
            if (r_idx == c_idx_last) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + c_iw'(1);
            end
         end else if (w_tick) begin
            r_tick <= r_tick + c_tw'(1);
         end
      end
   end

   // Shadow copies only move at the frame boundary so a frame is never torn.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dig_sh     <= '0;
         r_dp_sh      <= '0;
         r_en_sh      <= '0;
         r_frame_pend <= 1'b0;
      end else begin
         r_frame_pend <= w_frame_wrap;
         if (w_frame_wrap) begin
            r_dig_sh <= digits;
            r_dp_sh  <= dp;
            r_en_sh  <= digit_en;
         end
      end
   end

   // Lit-window lookup, one entry per representable tick value.
   for (genvar gi = 0; gi < (2**c_tw); gi++) begin : g_win
      assign w_win[gi] = (gi >= ON_FIRST) && (gi <= ON_LAST);
   end

   for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_dig
      assign w_dig_arr[gd] = r_dig_sh[4*gd +: 4];
   end

   assign w_cur_dig = w_dig_arr[r_idx];
   assign w_cur_dp  = r_dp_sh[r_idx];
   assign w_lit     = w_win[r_tick] && r_en_sh[r_idx];
   assign w_an_sel  = ~(NUM_DIGITS'(1) << r_idx);

   always_comb begin
      w_seg_dec = c_seg_off;
      case (w_cur_dig)
         4'h0:    w_seg_dec = 7'h40;
         4'h1:    w_seg_dec = 7'h79;
         4'h2:    w_seg_dec = 7'h24;
         4'h3:    w_seg_dec = 7'h30;
         4'h4:    w_seg_dec = 7'h19;
         4'h5:    w_seg_dec = 7'h12;
         4'h6:    w_seg_dec = 7'h02;
         4'h7:    w_seg_dec = 7'h78;
         4'h8:    w_seg_dec = 7'h00;
         4'h9:    w_seg_dec = 7'h10;
         4'hA:    w_seg_dec = 7'h08;
         4'hB:    w_seg_dec = 7'h03;
         4'hC:    w_seg_dec = 7'h46;
         4'hD:    w_seg_dec = 7'h21;
         4'hE:    w_seg_dec = 7'h06;
         default: w_seg_dec = 7'h0E;
      endcase
   end

   // All pin-facing outputs share one register stage so they move together.
   always_ff @(posedge clk) begin
      if (reset) begin
         an          <= '1;
         seg         <= c_seg_off;
         dp_n        <= 1'b1;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         an          <= w_lit ? w_an_sel : '1;
         seg         <= w_lit ? w_seg_dec : c_seg_off;
         dp_n        <= w_lit ? ~w_cur_dp : 1'b1;
         digit_idx   <= r_idx;
         frame_start <= r_frame_pend;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_anode_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_anode_scanner
//  Purpose  : Self-checking bench: 4-digit legacy-style scan and 8-digit
//             wide-window scan against a cycle-count arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_anode_scanner;

   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dpn;
      logic [2:0] idx;
      logic       fs;
   } exp_t;

   localparam exp_t BLANK = '{an: 8'hFF, seg: 7'h7F, dpn: 1'b1, idx: 3'd0, fs: 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-digit instance
   logic        reset4;
   logic [15:0] digits4;
   logic [3:0]  dp4, en4, an4;
   logic [6:0]  seg4;
   logic        dp_n4, frame_start4;
   logic [1:0]  digit_idx4;

   // 8-digit instance
   logic        reset8;
   logic [31:0] digits8;
   logic [7:0]  dp8, en8, an8;
   logic [6:0]  seg8;
   logic        dp_n8, frame_start8;
   logic [2:0]  digit_idx8;

   anode_scanner #(.NUM_DIGITS(4), .TICK_DIV(1), .SLOT_TICKS(4), .ON_FIRST(2), .ON_LAST(2)) dut4 (
      .clk(clk), .reset(reset4), .digits(digits4), .dp(dp4), .digit_en(en4),
      .an(an4), .seg(seg4), .dp_n(dp_n4), .digit_idx(digit_idx4), .frame_start(frame_start4));

   anode_scanner #(.NUM_DIGITS(8), .TICK_DIV(3), .SLOT_TICKS(5), .ON_FIRST(1), .ON_LAST(3)) dut8 (
      .clk(clk), .reset(reset8), .digits(digits8), .dp(dp8), .digit_en(en8),
      .an(an8), .seg(seg8), .dp_n(dp_n8), .digit_idx(digit_idx8), .frame_start(frame_start8));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Expected outputs produced by the edge that leaves state k (k = non-reset
   // edges since reset), derived purely from tick arithmetic.
   function automatic exp_t model(input int k, input int n, input int d, input int s,
                                  input int of, input int ol, input logic [31:0] dsh,
                                  input logic [7:0] dpsh, input logic [7:0] ensh);
      exp_t e;
      int t, tc, id;
      t  = k / d;
      tc = t % s;
      id = (t / s) % n;
      e      = BLANK;
      e.idx  = id[2:0];
      e.fs   = (k > 0) && ((k % (d * s * n)) == 0);
      if (tc >= of && tc <= ol && ensh[id]) begin
         e.an[id] = 1'b0;
         e.seg    = HEX[dsh[id*4 +: 4]];
         e.dpn    = ~dpsh[id];
      end
      return e;
   endfunction

   int          k4 = 0, k8 = 0;
   logic        v4 = 1'b0, v8 = 1'b0;
   exp_t        e4, e8;
   logic [31:0] dsh4, dsh8;
   logic [7:0]  dpsh4, ensh4, dpsh8, ensh8;

   always @(posedge clk) begin
      if (reset4) begin
         k4 <= 0; dsh4 <= '0; dpsh4 <= '0; ensh4 <= '0; e4 <= BLANK; v4 <= 1'b1;
      end else begin
         e4 <= model(k4, 4, 1, 4, 2, 2, dsh4, dpsh4, ensh4);
         k4 <= k4 + 1;
         if (((k4 + 1) % 16) == 0) begin
            dsh4 <= {16'h0, digits4}; dpsh4 <= {4'h0, dp4}; ensh4 <= {4'h0, en4};
         end
      end
   end

   always @(posedge clk) begin
      if (reset8) begin
         k8 <= 0; dsh8 <= '0; dpsh8 <= '0; ensh8 <= '0; e8 <= BLANK; v8 <= 1'b1;
      end else begin
         e8 <= model(k8, 8, 3, 5, 1, 3, dsh8, dpsh8, ensh8);
         k8 <= k8 + 1;
         if (((k8 + 1) % 120) == 0) begin
            dsh8 <= digits8; dpsh8 <= dp8; ensh8 <= en8;
         end
      end
   end

   // Per-cycle comparison against the model plus run-length / wrap checks.
   int         run8 = 0;
   logic [2:0] prev_idx8 = 3'd0;
   always @(negedge clk) begin
      if (v4) begin
         chk("an4", {28'h0, an4}, {28'h0, e4.an[3:0]});
         chk("seg4", {25'h0, seg4}, {25'h0, e4.seg});
         chk("dpn4", {31'h0, dp_n4}, {31'h0, e4.dpn});
         chk("idx4", {30'h0, digit_idx4}, {30'h0, e4.idx[1:0]});
         chk("fs4", {31'h0, frame_start4}, {31'h0, e4.fs});
         chk("onehot4", {31'h0, ($countones(~an4) <= 1)}, 32'd1);
      end
      if (v8) begin
         chk("an8", {24'h0, an8}, {24'h0, e8.an});
         chk("seg8", {25'h0, seg8}, {25'h0, e8.seg});
         chk("dpn8", {31'h0, dp_n8}, {31'h0, e8.dpn});
         chk("idx8", {29'h0, digit_idx8}, {29'h0, e8.idx});
         chk("fs8", {31'h0, frame_start8}, {31'h0, e8.fs});
         chk("onehot8", {31'h0, ($countones(~an8) <= 1)}, 32'd1);
         if (an8[0] == 1'b0) begin
            run8 = run8 + 1;
         end else if (run8 > 0) begin
            chk("an8_0_run", run8, 32'd9);
            run8 = 0;
         end
         if (prev_idx8 == 3'd7 && digit_idx8 == 3'd0)
            chk("wrap_fs8", {31'h0, frame_start8}, 32'd1);
         prev_idx8 = digit_idx8;
      end
   end

   task automatic wait_k4(input int target);
      int n = 0;
      while (k4 != target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (k4 != target) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_k4: reached %0d expected %0d", k4, target);
      end
   endtask

   initial begin
      reset4 = 1'b1; reset8 = 1'b1;
      digits4 = 16'h3210; dp4 = 4'h0; en4 = 4'hF;
      digits8 = 32'h7654_3210; dp8 = 8'hA5; en8 = 8'hFF;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_an4", {28'h0, an4}, 32'hF);
         chk("rst_seg4", {25'h0, seg4}, 32'h7F);
      end
      reset4 = 1'b0; reset8 = 1'b0;

      // Second frame of the 4-digit scan: digits 0..3 lit in order.
      wait_k4(17); chk("lit_fs_first", {31'h0, frame_start4}, 32'd1);
      wait_k4(19); chk("lit_an_d0", {28'h0, an4}, 32'hE); chk("lit_seg_d0", {25'h0, seg4}, 32'h40);
      wait_k4(21); chk("idx_is_1", {30'h0, digit_idx4}, 32'd1);
      digits4 = 16'hFFFF;
      wait_k4(23); chk("lit_an_d1", {28'h0, an4}, 32'hD); chk("lit_seg_d1", {25'h0, seg4}, 32'h79);
      wait_k4(27); chk("lit_an_d2", {28'h0, an4}, 32'hB); chk("lit_seg_d2", {25'h0, seg4}, 32'h24);
      wait_k4(31); chk("lit_an_d3", {28'h0, an4}, 32'h7); chk("lit_seg_d3", {25'h0, seg4}, 32'h30);
      wait_k4(33); chk("snap_fs", {31'h0, frame_start4}, 32'd1);
      wait_k4(35); chk("snap_seg_d0", {25'h0, seg4}, 32'h0E);
      wait_k4(39); chk("snap_seg_d1", {25'h0, seg4}, 32'h0E);

      // Enable mask and decimal point, effective from the frame at k=48.
      wait_k4(40);
      en4 = 4'b0101; dp4 = 4'b0100;
      wait_k4(51); chk("en_an_d0", {28'h0, an4}, 32'hE); chk("en_dpn_d0", {31'h0, dp_n4}, 32'd1);
      wait_k4(55); chk("en_an_d1", {28'h0, an4}, 32'hF); chk("en_seg_d1", {25'h0, seg4}, 32'h7F);
      wait_k4(59); chk("en_an_d2", {28'h0, an4}, 32'hB); chk("en_dpn_d2", {31'h0, dp_n4}, 32'd0);

      // Reset while digit 2 is lit.
      reset4 = 1'b1;
      @(negedge clk);
      chk("mid_rst_an", {28'h0, an4}, 32'hF);
      chk("mid_rst_idx", {30'h0, digit_idx4}, 32'd0);
      reset4 = 1'b0;
      wait_k4(11); chk("post_rst_dark", {28'h0, an4}, 32'hF);
      wait_k4(19); chk("post_rst_lit", {28'h0, an4}, 32'hE); chk("post_rst_seg", {25'h0, seg4}, 32'h0E);

      for (int i = 0; i < 1000 && k8 < 270; i++) @(negedge clk);
      chk("k8_budget", {31'h0, (k8 >= 270)}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
